intra_residue_gen: RTL and testbench
====================================

// Module: intra_residue_gen
// PURPOSE
//  Encoder-side counterpart of intra reconstruction: receives one original MB plus top/left neighbours.
//  Computes V, H and DC predictions and accumulates a SAD per mode while buffering the MB.
//  Selects the lowest-SAD mode, then streams residue = orig - pred with the chosen mode to the transform/entropy stage.
//  Mode codes and DC rule are bit-exact with the decoder: 0=V, 1=H, 2=DC, DC=(sumT+sumL)>>log2(2*MB_SIZE), unavailable edge=128.
// PARAMETERS
//  MB_SIZE   16  MB edge in pixels; legal 4, 8, 16 (square only)
//  PIX_W     8   pixel width
//  RES_W     9   residue width, signed
//  SAD_W     16  per-mode SAD accumulator width (fits 256*255)
// PORTS
//  clk        in   1            clock, all state on posedge
//  reset      in   1            asynchronous, active-low; clears all state and outputs
//  start      in   1            begin MB; sampled only in IDLE, ignored otherwise
//  mbnumber   in   13           MB index; latched on start, echoed on mb_out
//  top_in     in   PIX_W x MB   top neighbours, latched on start
//  left_in    in   PIX_W x MB   left neighbours, latched on start
//  top_avail  in   1            0 -> all top neighbours forced to 128
//  left_avail in   1            0 -> all left neighbours forced to 128
//  pix_valid  in   1            original pixel valid (raster order within MB)
//  pix_ready  out  1            high only in LOAD
//  pix_data   in   PIX_W        original pixel
//  res_valid  out  1            residue valid (EMIT)
//  res_ready  in   1            downstream accepts residue
//  res_data   out  RES_W        signed residue, raster order
//  res_last   out  1            with final residue (index MB*MB-1)
//  mode_out   out  3            chosen mode; valid while mode_valid
//  sad_out    out  SAD_W        SAD of chosen mode
//  mb_out     out  13           latched mbnumber
//  mode_valid out  1            high from DECIDE exit until next start
//  busy       out  1            state != IDLE
//  done       out  1            1-cycle pulse on return to IDLE
// BEHAVIOUR
//  Reset values: all outputs 0; state IDLE; counters and SADs 0.
//  FSM: IDLE -start-> PREP (1 cycle: apply avail masks, compute DC) -> LOAD -> DECIDE (1 cycle) -> EMIT -> IDLE.
//  LOAD: pix_ready=1; each pix_valid&pix_ready writes buf[idx] and adds |p-predV|, |p-predH|, |p-predDC| to its SAD.
//   predV=top[idx%MB], predH=left[idx/MB]; gaps in pix_valid stall, leaving SADs unchanged.
//  Leave LOAD on acceptance of pixel MB*MB-1; idx wraps to 0.
//  DECIDE: strict less-than compare in order V, H, DC; ties resolve to lowest code (V>H>DC priority). Latch mode/sad, set mode_valid.
//  EMIT: res_valid=1; res_data=buf[idx]-pred_mode[idx], sign-extended to RES_W.
//   Advance idx on res_valid&res_ready; res_data/res_last stable while stalled.
//  Exit EMIT after the res_last handshake; done=1 in first IDLE cycle.
//  Throughput with no stalls: start at edge t -> pix_ready from t+2 -> first res_valid at t+2+MB*MB+1.
//  start while busy: ignored, no effect on current MB. Reset mid-operation: immediate IDLE, outputs 0, buffer content don't-care.
//  Full-scale residue range without saturation: -255..+255.
// CONFIGURATION
//  INTRA_RES_SAT8_EN defined: res_data clamped to [-128,+127] (matches 8-bit residue storage downstream); SAD unaffected.
//  Undefined: full 9-bit residue, no clamp.
// STRUCTURE
//  intra_pkg: mode_e enum (MODE_V=0, MODE_H=1, MODE_DC=2), state_e enum, PIX_W/RES_W/SAD_W constants, function sat8().
//  Sub-module intra_sad_acc: clear/enable abs-diff accumulator; instantiated 3x (V, H, DC).
//  MB buffer: MB*MB x PIX_W register array, single write (LOAD) / single read (EMIT) port.
// TESTING
//  1 all pix=100, top=100, left=50, both avail -> mode 0, sad 0, 256 residues 0, res_last on #256.
//  2 row r pixels = left[r] = 10*r, top=200 -> mode 1, sad 0, all residues 0.
//  3 avail=0/0, pix=128 -> all SADs 0, tie -> mode 0, residues 0.
//  4 pix=0, top=left=255 avail -> mode 0; residues -255, or -128 with INTRA_RES_SAT8_EN.
//  5 pix_valid every 3rd cycle, res_ready toggling -> identical results to case 1; data held on stall; exactly 256 handshakes.
//  6 reset low after 100 pixels -> busy=0, outputs 0; following start + clean MB matches case 1 exactly.

Source files
------------

// File: rtl/intra_pkg.sv
// intra_pkg: shared types, widths and the 8-bit residue clamp for intra_residue_gen.
package intra_pkg;
    localparam int PIX_W = 8;
    localparam int RES_W = 9;
    localparam int SAD_W = 16;
    localparam logic signed [RES_W-1:0] SAT_HI = RES_W'(127);
    localparam logic signed [RES_W-1:0] SAT_LO = RES_W'(-128);
    typedef enum logic [2:0] {MODE_V = 3'd0, MODE_H = 3'd1, MODE_DC = 3'd2} mode_e;
    typedef enum logic [2:0] {IDLE, PREP, LOAD, DECIDE, EMIT} state_e;
    function automatic logic signed [RES_W-1:0] sat8(input logic signed [RES_W-1:0] v);
        return (v > SAT_HI) ? SAT_HI : (v < SAT_LO) ? SAT_LO : v;
    endfunction
endpackage

// File: rtl/intra_sad_acc.sv
// intra_sad_acc: absolute-difference accumulator with synchronous clear and enable.
module intra_sad_acc #(
    parameter int PIX_W = 8,
    parameter int SAD_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             en,
    input  logic [PIX_W-1:0] a,
    input  logic [PIX_W-1:0] b,
    output logic [SAD_W-1:0] sad
);
    logic [PIX_W-1:0] d;
    assign d = (a > b) ? a - b : b - a;
    always_ff @(posedge clk or negedge reset)
        if (!reset)     sad <= '0;
        else if (clear) sad <= '0;
        else if (en)    sad <= sad + SAD_W'(d);
endmodule

// File: rtl/intra_residue_gen.sv
// intra_residue_gen: buffers one MB, picks the lowest-SAD V/H/DC intra mode and streams orig - pred.
// Optional macro INTRA_RES_SAT8_EN clamps the emitted residue to [-128,+127].
module intra_residue_gen import intra_pkg::*; #(
    parameter int MB_SIZE = 16,
    parameter int PIX_W   = intra_pkg::PIX_W,
    parameter int RES_W   = intra_pkg::RES_W,
    parameter int SAD_W   = intra_pkg::SAD_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [12:0]              mbnumber,
    input  logic [MB_SIZE*PIX_W-1:0] top_in,
    input  logic [MB_SIZE*PIX_W-1:0] left_in,
    input  logic                     top_avail,
    input  logic                     left_avail,
    input  logic                     pix_valid,
    output logic                     pix_ready,
    input  logic [PIX_W-1:0]         pix_data,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic signed [RES_W-1:0]  res_data,
    output logic                     res_last,
    output logic [2:0]               mode_out,
    output logic [SAD_W-1:0]         sad_out,
    output logic [12:0]              mb_out,
    output logic                     mode_valid,
    output logic                     busy,
    output logic                     done
);
    localparam int LOG = $clog2(MB_SIZE);
    localparam int IW  = 2 * LOG;
    localparam int N   = MB_SIZE * MB_SIZE;
    localparam int DW  = PIX_W + LOG + 1;
    localparam logic [IW-1:0]    LAST = IW'(N - 1);
    localparam logic [PIX_W-1:0] MID  = PIX_W'(128);

    state_e                  state;
    mode_e                   mode_r, best_mode;
    logic [IW-1:0]           idx;
    logic                    ta_r, la_r, pix_acc;
    logic [PIX_W-1:0]        top_r [MB_SIZE];
    logic [PIX_W-1:0]        left_r [MB_SIZE];
    logic [PIX_W-1:0]        mem [N];
    logic [PIX_W-1:0]        dc_r, pv, ph, pm, cur;
    logic [DW-1:0]           dc_sum;
    logic [SAD_W-1:0]        sad_v, sad_h, sad_d, best_vh, best_sad;
    logic signed [RES_W-1:0] diff, res;

    assign pix_ready = state == LOAD;
    assign res_valid = state == EMIT;
    assign busy      = state != IDLE;
    assign pix_acc   = pix_valid && pix_ready;
    assign mode_out  = mode_r;

    assign pv  = top_r[idx[LOG-1:0]];
    assign ph  = left_r[idx[IW-1:LOG]];
    assign cur = mem[idx];
    assign pm  = (mode_r == MODE_V) ? pv : (mode_r == MODE_H) ? ph : dc_r;

    // V, H, DC order with strict less-than so ties keep the lower mode code
    assign best_vh   = (sad_h < sad_v) ? sad_h : sad_v;
    assign best_sad  = (sad_d < best_vh) ? sad_d : best_vh;
    assign best_mode = (sad_d < best_vh) ? MODE_DC : (sad_h < sad_v) ? MODE_H : MODE_V;

    assign diff = RES_W'($signed({1'b0, cur}) - $signed({1'b0, pm}));
`ifdef INTRA_RES_SAT8_EN
    assign res = sat8(diff);
`else
    assign res = diff;
`endif
    assign res_data = res_valid ? res : '0;
    assign res_last = res_valid && idx == LAST;

    always_comb begin
        dc_sum = '0;
        for (int i = 0; i < MB_SIZE; i++)
            dc_sum = dc_sum + DW'(ta_r ? top_r[i] : MID) + DW'(la_r ? left_r[i] : MID);
    end

    intra_sad_acc #(.PIX_W(PIX_W), .SAD_W(SAD_W)) u_sad_v (
        .clk(clk), .reset(reset), .clear(state == PREP), .en(pix_acc),
        .a(pix_data), .b(pv), .sad(sad_v));
    intra_sad_acc #(.PIX_W(PIX_W), .SAD_W(SAD_W)) u_sad_h (
        .clk(clk), .reset(reset), .clear(state == PREP), .en(pix_acc),
        .a(pix_data), .b(ph), .sad(sad_h));
    intra_sad_acc #(.PIX_W(PIX_W), .SAD_W(SAD_W)) u_sad_dc (
        .clk(clk), .reset(reset), .clear(state == PREP), .en(pix_acc),
        .a(pix_data), .b(dc_r), .sad(sad_d));

    always_ff @(posedge clk)
        if (pix_acc) mem[idx] <= pix_data;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            idx        <= '0;
            mode_r     <= MODE_V;
            sad_out    <= '0;
            mb_out     <= '0;
            mode_valid <= 1'b0;
            done       <= 1'b0;
            ta_r       <= 1'b0;
            la_r       <= 1'b0;
            dc_r       <= '0;
            for (int i = 0; i < MB_SIZE; i++) begin
                top_r[i]  <= '0;
                left_r[i] <= '0;
            end
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    state      <= PREP;
                    mb_out     <= mbnumber;
                    mode_valid <= 1'b0;
                    ta_r       <= top_avail;
                    la_r       <= left_avail;
                    for (int i = 0; i < MB_SIZE; i++) begin
                        top_r[i]  <= top_in[i*PIX_W +: PIX_W];
                        left_r[i] <= left_in[i*PIX_W +: PIX_W];
                    end
                end
                PREP: begin
                    state <= LOAD;
                    idx   <= '0;
                    dc_r  <= PIX_W'(dc_sum >> (LOG + 1));
                    for (int i = 0; i < MB_SIZE; i++) begin
                        top_r[i]  <= ta_r ? top_r[i] : MID;
                        left_r[i] <= la_r ? left_r[i] : MID;
                    end
                end
                LOAD: if (pix_valid) begin
                    idx <= idx + 1'b1;
                    if (idx == LAST) state <= DECIDE;
                end
                DECIDE: begin
                    state      <= EMIT;
                    mode_r     <= best_mode;
                    sad_out    <= best_sad;
                    mode_valid <= 1'b1;
                end
                EMIT: if (res_ready) begin
                    idx <= idx + 1'b1;
                    if (idx == LAST) begin
                        state <= IDLE;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_intra_residue_gen.sv
// tb_intra_residue_gen: directed vector table plus stall, busy-start and mid-MB reset sequences.
module tb_intra_residue_gen;
    localparam int MB = 16;
    localparam int N  = MB * MB;
    localparam int PW = 8;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              start = 1'b0;
    logic [12:0]       mbnumber = '0;
    logic [MB*PW-1:0]  top_in = '0;
    logic [MB*PW-1:0]  left_in = '0;
    logic              top_avail = 1'b0;
    logic              left_avail = 1'b0;
    logic              pix_valid = 1'b0;
    logic              pix_ready;
    logic [PW-1:0]     pix_data = '0;
    logic              res_valid;
    logic              res_ready = 1'b0;
    logic signed [8:0] res_data;
    logic              res_last;
    logic [2:0]        mode_out;
    logic [15:0]       sad_out;
    logic [12:0]       mb_out;
    logic              mode_valid, busy, done;

    intra_residue_gen dut (
        .clk(clk), .reset(reset), .start(start), .mbnumber(mbnumber),
        .top_in(top_in), .left_in(left_in), .top_avail(top_avail), .left_avail(left_avail),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_last(res_last),
        .mode_out(mode_out), .sad_out(sad_out), .mb_out(mb_out), .mode_valid(mode_valid),
        .busy(busy), .done(done));

    always #5 clk = ~clk;

    // pixel = pb + ps*row, left[r] = lb + ls*r, top uniform tv; er is the raw residue of every pixel
    typedef struct {
        int pb, ps, tv, lb, ls;
        bit ta, la;
        int em, es, er;
    } vec_t;

    vec_t vecs[6];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int exp_res(input int r);
`ifdef INTRA_RES_SAT8_EN
        return (r > 127) ? 127 : (r < -128) ? -128 : r;
`else
        return r;
`endif
    endfunction

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_pix_ready"}, pix_ready, 0);
        chk({tag, "_res_valid"}, res_valid, 0);
        chk({tag, "_res_data"}, res_data, 0);
        chk({tag, "_res_last"}, res_last, 0);
        chk({tag, "_mode"}, mode_out, 0);
        chk({tag, "_sad"}, sad_out, 0);
        chk({tag, "_mb"}, mb_out, 0);
        chk({tag, "_mode_valid"}, mode_valid, 0);
        chk({tag, "_done"}, done, 0);
    endtask

    task automatic setup(input vec_t v, input int mbn);
        for (int i = 0; i < MB; i++) begin
            top_in[i*PW +: PW]  = PW'(v.tv);
            left_in[i*PW +: PW] = PW'(v.lb + v.ls * i);
        end
        top_avail  = v.ta;
        left_avail = v.la;
        mbnumber   = 13'(mbn);
    endtask

    task automatic run_mb(input vec_t v, input int mbn, input int gap, input bit stall, input string tag);
        int k, cyc, sent, hs, bad, lastpos, lastcnt, stallbad, hd, hl;
        bit acc, held, rr;
        setup(v, mbn);
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        k = 1;
        chk({tag, "_busy_on"}, busy, 1);
        chk({tag, "_ready_early"}, pix_ready, 0);
        @(negedge clk) k++;
        chk({tag, "_ready_k2"}, pix_ready, 1);
        sent = 0;
        cyc = 0;
        while (sent < N && cyc < 3000) begin
            pix_valid = (cyc % gap) == 0;
            pix_data  = PW'(v.pb + v.ps * (sent / MB));
            if (stall) begin
                start    = cyc == 7;
                mbnumber = (cyc == 7) ? 13'h1fff : 13'(mbn);
            end
            acc = pix_valid && pix_ready;
            @(negedge clk) k++;
            cyc++;
            if (acc) sent++;
        end
        pix_valid = 1'b0;
        start     = 1'b0;
        chk({tag, "_pixels"}, sent, N);
        while (!res_valid && cyc < 3000) begin
            @(negedge clk) k++;
            cyc++;
        end
        if (gap == 1) chk({tag, "_res_latency"}, k, N + 3);
        chk({tag, "_mode"}, mode_out, v.em);
        chk({tag, "_sad"}, sad_out, v.es);
        chk({tag, "_mb"}, mb_out, mbn);
        chk({tag, "_mode_valid"}, mode_valid, 1);
        hs = 0; bad = 0; lastpos = -1; lastcnt = 0; stallbad = 0; held = 0; hd = 0; hl = 0;
        while (hs < N && cyc < 6000) begin
            rr = stall ? cyc[0] : 1'b1;
            res_ready = rr;
            if (held && res_valid && (int'(res_data) != hd || int'(res_last) != hl)) stallbad++;
            if (res_valid && rr) begin
                if (int'(res_data) != exp_res(v.er)) bad++;
                if (res_last) begin
                    lastpos = hs;
                    lastcnt++;
                end
                hs++;
            end
            held = res_valid && !rr;
            hd = int'(res_data);
            hl = int'(res_last);
            @(negedge clk) k++;
            cyc++;
        end
        res_ready = 1'b0;
        chk({tag, "_handshakes"}, hs, N);
        chk({tag, "_res_bad"}, bad, 0);
        chk({tag, "_last_pos"}, lastpos, N - 1);
        chk({tag, "_last_cnt"}, lastcnt, 1);
        if (stall) chk({tag, "_stall_hold"}, stallbad, 0);
        chk({tag, "_done"}, done, 1);
        chk({tag, "_busy_off"}, busy, 0);
        chk({tag, "_res_valid_off"}, res_valid, 0);
        @(negedge clk);
        chk({tag, "_done_pulse"}, done, 0);
        chk({tag, "_mode_valid_hold"}, mode_valid, 1);
    endtask

    initial begin
        vecs[0] = '{100, 0, 100, 50, 0, 1, 1, 0, 0, 0};
        vecs[1] = '{0, 10, 200, 0, 10, 1, 1, 1, 0, 0};
        vecs[2] = '{128, 0, 7, 9, 0, 0, 0, 0, 0, 0};
        vecs[3] = '{0, 0, 255, 255, 0, 1, 1, 0, 65280, -255};
        vecs[4] = '{100, 0, 0, 90, 0, 0, 1, 2, 2304, -9};
        vecs[5] = '{60, 0, 0, 70, 0, 1, 1, 1, 2560, -10};
        @(negedge clk);
        check_idle_outputs("reset");
        @(negedge clk) reset = 1'b1;
        for (int i = 0; i < 6; i++) run_mb(vecs[i], 100 + i, 1, 1'b0, $sformatf("vec%0d", i));
        run_mb(vecs[0], 77, 3, 1'b1, "stall");
        setup(vecs[0], 55);
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 100; i++) begin
            pix_valid = 1'b1;
            pix_data  = 8'd100;
            @(negedge clk);
        end
        pix_valid = 1'b0;
        reset = 1'b0;
        #1;
        check_idle_outputs("midreset");
        @(negedge clk) reset = 1'b1;
        run_mb(vecs[0], 88, 1, 1'b0, "after_reset");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
